program_loader: RTL

Boot-time loader that sits directly upstream of the computer core and its program memory. It receives a framed byte stream on a valid/ready interface and assembles little-endian instructions. It writes them to program memory, fills the unused tail with HALT, and verifies an XOR checksum. The core is held in reset until a load completes cleanly. This replaces backdoor program-memory initialisation for integration and FPGA bring-up.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader_word_assembler.sv | 68 ++++++
 rtl/program_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: loader state
// encoding, stream field widths and the architectural HALT instruction.
package program_loader_pkg;

  localparam int LOADER_BYTE_WIDTH  = 8;
  localparam int LOADER_COUNT_WIDTH = 16;

  // Architectural HALT opcode, zero-extended so any legal instruction
  // width can take its low slice as the fill word.
  localparam logic [63:0] HALT_INST = 64'h0000_0000_0000_F000;

  typedef enum logic [2:0] {
    ST_COUNT_LO = 3'd0,
    ST_COUNT_HI = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_CHECKSUM = 3'd3,
    ST_FILL     = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } loader_state_e;

  // States in which the loader is willing to take a stream byte.
  function automatic logic is_receiving(input loader_state_e s);
    return (s == ST_COUNT_LO) || (s == ST_COUNT_HI) ||
           (s == ST_PAYLOAD)  || (s == ST_CHECKSUM);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// The loader is the slave of the stream and drives the memory writes.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH      = 16,
  parameter int PROG_MEMORY_SIZE = 1024
);

  localparam int ADDR_W = $clog2(PROG_MEMORY_SIZE);

  logic [LOADER_BYTE_WIDTH-1:0] rx_data;
  logic                         rx_valid;
  logic                         rx_ready;
  logic                         prog_write_enable;
  logic [ADDR_W-1:0]            prog_write_address;
  logic [INSTR_WIDTH-1:0]       prog_write_data;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, prog_write_enable, prog_write_address, prog_write_data
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, prog_write_enable, prog_write_address, prog_write_data
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Little-endian instruction assembler: shifts accepted payload bytes in
// from the top so byte k ends up at bits [8k+7:8k], and publishes the
// finished word with a one-cycle completion pulse.
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         byte_valid,
  input  logic [LOADER_BYTE_WIDTH-1:0] byte_data,
  output logic [INSTR_WIDTH-1:0]       word,
  output logic                         word_complete,
  output logic                         last_byte
);

  localparam int BYTES = INSTR_WIDTH / LOADER_BYTE_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [INSTR_WIDTH-1:0]                   shift_q;
  logic [INSTR_WIDTH+LOADER_BYTE_WIDTH-1:0] shift_cat;
  logic [INSTR_WIDTH-1:0]                   shift_next;
  logic [CNT_W-1:0]                         cnt_q;
  logic [INSTR_WIDTH-1:0]                   word_q;
  logic                                     complete_q;

  // The widened concatenation keeps the shift legal for single-byte words.
  assign shift_cat  = {byte_data, shift_q};
  assign shift_next = shift_cat[INSTR_WIDTH+LOADER_BYTE_WIDTH-1:LOADER_BYTE_WIDTH];
  assign last_byte  = (cnt_q == CNT_W'(BYTES - 1));

  // Byte lanes: pure data, only cleared when a new load starts.
  always_ff @(posedge clock) begin
    if (clear) begin
      shift_q <= '0;
    end else if (byte_valid) begin
      shift_q <= shift_next;
    end
  end

  // Byte counter, published word and completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      word_q     <= '0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      if (clear) begin
        cnt_q <= '0;
      end else if (byte_valid) begin
        if (last_byte) begin
          cnt_q      <= '0;
          word_q     <= shift_next;
          complete_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign word          = word_q;
  assign word_complete = complete_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Parses a framed byte stream
// (count, payload, XOR checksum), writes the instructions to program
// memory, pads the remainder with HALT and releases the core only after
// a clean load.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                     INSTR_WIDTH      = 16,
  parameter int                     PROG_MEMORY_SIZE = 1024,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD        = HALT_INST[INSTR_WIDTH-1:0]
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            restart,
  program_loader_if.slave bus,
  output logic            core_reset,
  output logic            load_done,
  output logic            load_error
);

  localparam int                             ADDR_W    = $clog2(PROG_MEMORY_SIZE);
  localparam logic [ADDR_W-1:0]              LAST_ADDR = ADDR_W'(PROG_MEMORY_SIZE - 1);
  localparam logic [LOADER_COUNT_WIDTH-1:0]  MEM_WORDS = LOADER_COUNT_WIDTH'(PROG_MEMORY_SIZE);

  loader_state_e                  state_q, state_d;
  logic                           armed_q;
  logic [LOADER_BYTE_WIDTH-1:0]   count_lo_q;
  logic [LOADER_COUNT_WIDTH-1:0]  count_q;
  logic [LOADER_COUNT_WIDTH-1:0]  remain_q;
  logic [LOADER_COUNT_WIDTH-1:0]  count_full;
  logic [LOADER_BYTE_WIDTH-1:0]   csum_q;
  logic [ADDR_W-1:0]              addr_q;
  logic                           halt_sel_q;

  logic                           accept;
  logic                           payload_accept;
  logic                           restart_take;
  logic                           write_en;
  logic [INSTR_WIDTH-1:0]         asm_word;
  logic                           asm_complete;
  logic                           asm_last;

  // rx_ready is held low until the first edge after reset is released.
  assign bus.rx_ready   = armed_q && is_receiving(state_q);
  assign accept         = bus.rx_valid && bus.rx_ready;
  assign payload_accept = accept && (state_q == ST_PAYLOAD);
  assign restart_take   = restart && ((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign count_full     = {bus.rx_data, count_lo_q};

  loader_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_assembler (
    .clock         (clock),
    .reset         (reset),
    .clear         (restart_take),
    .byte_valid    (payload_accept),
    .byte_data     (bus.rx_data),
    .word          (asm_word),
    .word_complete (asm_complete),
    .last_byte     (asm_last)
  );

  // Payload writes follow the assembler pulse; FILL writes every cycle.
  // The data select stays on HALT after FILL so the bus does not toggle
  // while idle.
  assign write_en               = asm_complete || (state_q == ST_FILL);
  assign bus.prog_write_enable  = write_en;
  assign bus.prog_write_address = addr_q;
  assign bus.prog_write_data    = halt_sel_q ? HALT_WORD : asm_word;

  assign load_done  = (state_q == ST_DONE);
  assign load_error = (state_q == ST_ERROR);
  assign core_reset = (state_q == ST_DONE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COUNT_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode for the frame parser.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COUNT_LO: begin
        if (accept) state_d = ST_COUNT_HI;
      end
      ST_COUNT_HI: begin
        if (accept) begin
          if (count_full > MEM_WORDS)       state_d = ST_ERROR;
          else if (count_full == '0)        state_d = ST_CHECKSUM;
          else                              state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (payload_accept && asm_last && (remain_q == LOADER_COUNT_WIDTH'(1)))
          state_d = ST_CHECKSUM;
      end
      ST_CHECKSUM: begin
        if (accept) begin
          if (bus.rx_data != csum_q)        state_d = ST_ERROR;
          else if (count_q == MEM_WORDS)    state_d = ST_DONE;
          else                              state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (addr_q == LAST_ADDR) state_d = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (restart) state_d = ST_COUNT_LO;
      end
      default: state_d = ST_COUNT_LO;
    endcase
  end

  // Frame bookkeeping: count, remaining instructions, running XOR,
  // write address and fill-data select.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q    <= 1'b0;
      count_lo_q <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      halt_sel_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (restart_take) begin
        count_q    <= '0;
        remain_q   <= '0;
        csum_q     <= '0;
        addr_q     <= '0;
        halt_sel_q <= 1'b0;
      end else begin
        if (accept && (state_q != ST_CHECKSUM)) csum_q <= csum_q ^ bus.rx_data;
        if (accept && (state_q == ST_COUNT_LO)) count_lo_q <= bus.rx_data;
        if (accept && (state_q == ST_COUNT_HI)) begin
          count_q  <= count_full;
          remain_q <= count_full;
        end
        if (payload_accept && asm_last) remain_q <= remain_q - LOADER_COUNT_WIDTH'(1);
        // Saturate at the last word so a full program never wraps to 0.
        if (write_en && (addr_q != LAST_ADDR)) addr_q <= addr_q + ADDR_W'(1);
        if ((state_q == ST_CHECKSUM) && (state_d == ST_FILL)) halt_sel_q <= 1'b1;
      end
    end
  end

endmodule
